// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory request/response path
package mem_pkg;

    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_LS = 1'b1;

    typedef struct packed {
        logic tag;
        logic kill;
    } tag_entry_t;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order FIFO of read requester tags with bulk kill on flush
module tag_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    input  logic             flush,
    output logic             head_tag,
    output logic             head_kill,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    tag_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_tag  = entries[rd_ptr].tag;
    assign head_kill = entries[rd_ptr].kill;

    // Flush marks every slot; killing dead slots is harmless because a push
    // always rewrites its slot, and the push below overrides the flush mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].kill <= 1'b1;
                end
            end
            if (do_push) begin
                entries[wr_ptr] <= '{tag: push_tag, kill: 1'b0};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_resp_router.sv
// rtl/mem_resp_router.sv - steers returning memory read words to IF or LS by issue order
module mem_resp_router
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_tag,
    output logic                     issue_ready,
    input  logic                     flush,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     if_valid,
    output logic [DATA_W-1:0]        if_data,
    output logic                     ls_valid,
    output logic [DATA_W-1:0]        ls_data,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_orphan
);

    logic head_tag;
    logic head_kill;
    logic full;
    logic empty;
    logic do_pop;

    // full comes from the registered count only, so a same-cycle pop never
    // opens issue_ready combinationally.
    assign issue_ready = !full;
    assign do_pop      = mem_rvalid && !empty;

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_valid && issue_ready),
        .push_tag  (issue_tag),
        .pop       (do_pop),
        .flush     (flush),
        .head_tag  (head_tag),
        .head_kill (head_kill),
        .count     (outstanding),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid   <= 1'b0;
            ls_valid   <= 1'b0;
            if_data    <= '0;
            ls_data    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if_valid   <= 1'b0;
            ls_valid   <= 1'b0;
            err_orphan <= mem_rvalid && empty;
            if (do_pop && !head_kill) begin
                if (head_tag == TAG_LS) begin
                    ls_data  <= mem_rdata;
                    ls_valid <= 1'b1;
                end else begin
                    if_data  <= mem_rdata;
                    if_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_router.sv
// tb/tb_mem_resp_router.sv - directed self-checking bench for mem_resp_router
module tb_mem_resp_router;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_tag;
    logic              issue_ready;
    logic              flush;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_data;
    logic [2:0]        outstanding;
    logic              err_orphan;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mem_resp_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .flush       (flush),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .if_valid    (if_valid),
        .if_data     (if_data),
        .ls_valid    (ls_valid),
        .ls_data     (ls_data),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_tag   = 1'b0;
        flush       = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic issue(input logic t);
        idle_inputs();
        issue_valid = 1'b1;
        issue_tag   = t;
        step();
    endtask

    task automatic respond(input logic [31:0] d);
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        step();
    endtask

    logic        exp_q[$];
    logic        t_new;
    logic        t_head;
    logic [31:0] exp_if;
    logic [31:0] exp_ls;

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        check("rst_if_valid", if_valid, 0);
        check("rst_ls_valid", ls_valid, 0);
        check("rst_if_data", if_data, 0);
        check("rst_ls_data", ls_data, 0);
        check("rst_err_orphan", err_orphan, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_issue_ready", issue_ready, 1);
            check("idle_outstanding", outstanding, 0);
        end

        // IF, LS, IF then 0xA, 0xB, 0xC
        issue(0);
        issue(1);
        issue(0);
        check("seq_outstanding3", outstanding, 3);
        respond(32'hA);
        check("seq_a_if_valid", if_valid, 1);
        check("seq_a_if_data", if_data, 32'hA);
        check("seq_a_ls_valid", ls_valid, 0);
        check("seq_a_outstanding", outstanding, 2);
        respond(32'hB);
        check("seq_b_ls_valid", ls_valid, 1);
        check("seq_b_ls_data", ls_data, 32'hB);
        check("seq_b_if_valid", if_valid, 0);
        check("seq_b_outstanding", outstanding, 1);
        respond(32'hC);
        check("seq_c_if_valid", if_valid, 1);
        check("seq_c_if_data", if_data, 32'hC);
        check("seq_c_outstanding", outstanding, 0);
        idle_inputs();
        step();
        check("seq_if_pulse_end", if_valid, 0);

        // Fill to DEPTH, 5th issue ignored, pop reopens
        issue(0);
        issue(1);
        issue(0);
        issue(1);
        check("full_ready", issue_ready, 0);
        check("full_outstanding", outstanding, 4);
        issue(0);
        check("full_5th_ignored", outstanding, 4);
        respond(32'h11);
        check("full_pop_if_data", if_data, 32'h11);
        check("full_pop_outstanding", outstanding, 3);
        check("full_pop_ready", issue_ready, 1);
        respond(32'h12);
        check("full_ls_12", ls_data, 32'h12);
        respond(32'h13);
        check("full_if_13", if_data, 32'h13);
        respond(32'h14);
        check("full_ls_14", ls_data, 32'h14);
        check("full_drained", outstanding, 0);

        // Flush kills older entries but not the same-cycle push
        issue(0);
        issue(0);
        idle_inputs();
        issue_valid = 1'b1;
        issue_tag   = 1'b1;
        flush       = 1'b1;
        step();
        check("flush_outstanding", outstanding, 3);
        respond(32'h1);
        check("flush_1_if_valid", if_valid, 0);
        check("flush_1_ls_valid", ls_valid, 0);
        check("flush_1_if_data", if_data, 32'h13);
        respond(32'h2);
        check("flush_2_if_valid", if_valid, 0);
        check("flush_2_if_data", if_data, 32'h13);
        respond(32'h3);
        check("flush_3_ls_valid", ls_valid, 1);
        check("flush_3_ls_data", ls_data, 32'h3);
        check("flush_3_if_data", if_data, 32'h13);
        check("flush_3_outstanding", outstanding, 0);

        // Orphan response while empty
        respond(32'hDEAD);
        check("orph_err", err_orphan, 1);
        check("orph_if_valid", if_valid, 0);
        check("orph_ls_valid", ls_valid, 0);
        check("orph_if_data", if_data, 32'h13);
        check("orph_ls_data", ls_data, 32'h3);
        idle_inputs();
        step();
        check("orph_err_pulse_end", err_orphan, 0);

        // Orphan with same-cycle push: the new entry survives
        idle_inputs();
        issue_valid = 1'b1;
        issue_tag   = 1'b1;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hBEEF;
        step();
        check("orph_push_err", err_orphan, 1);
        check("orph_push_outstanding", outstanding, 1);
        check("orph_push_ls_data", ls_data, 32'h3);
        respond(32'h55);
        check("orph_push_resp", ls_data, 32'h55);
        check("orph_push_err_clear", err_orphan, 0);

        // Simultaneous push/pop at 2 outstanding across pointer wraps
        exp_if = if_data;
        exp_ls = ls_data;
        for (int i = 0; i < 2; i++) begin
            t_new = 1'($urandom_range(0, 1));
            exp_q.push_back(t_new);
            issue(t_new);
        end
        check("wrap_outstanding_start", outstanding, 2);
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i < 8) begin
                t_new = 1'($urandom_range(0, 1));
                issue_valid = 1'b1;
                issue_tag   = t_new;
                exp_q.push_back(t_new);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h100 + 32'(i);
            t_head = exp_q.pop_front();
            if (t_head) exp_ls = 32'h100 + 32'(i);
            else        exp_if = 32'h100 + 32'(i);
            step();
            check("wrap_if_valid", if_valid, {31'b0, !t_head});
            check("wrap_ls_valid", ls_valid, {31'b0, t_head});
            check("wrap_if_data", if_data, exp_if);
            check("wrap_ls_data", ls_data, exp_ls);
            check("wrap_outstanding", outstanding, (i < 8) ? 2 : 32'(9 - i));
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_resp_router.md
# mem_resp_router

Response-side router for the shared single-port instruction/data memory. It records which requester issued each outstanding read and steers each returning read word to that requester: the fetch stage (IF) or the load/store stage (LS). It sits between the memory read-data port and the two pipeline consumers, and is the return-path counterpart of the request-side 2:1 select into the memory. A pipeline flush cancels in-flight responses without losing FIFO alignment.

## Interface
Parameters:
- DATA_W, 32, memory read-data width
- DEPTH, 4, maximum outstanding reads; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  a read request is accepted by memory this cycle
- issue_tag  in  1  requester of that read: 0 = IF, 1 = LS
- issue_ready  out  1  tag FIFO can accept an issue
- flush  in  1  cancel all reads outstanding at this edge
- mem_rvalid  in  1  memory returns one read word this cycle
- mem_rdata  in  DATA_W  returned word
- if_valid  out  1  one-cycle pulse; if_data is new
- if_data  out  DATA_W  last word routed to IF; held between pulses
- ls_valid  out  1  one-cycle pulse; ls_data is new
- ls_data  out  DATA_W  last word routed to LS; held between pulses
- outstanding  out  $clog2(DEPTH)+1  number of live FIFO entries
- err_orphan  out  1  one-cycle pulse: mem_rvalid arrived with an empty FIFO

## Operation
- The tag FIFO holds entries of {tag, kill}, in order. A push happens when issue_valid && issue_ready and writes {issue_tag, 0}.
- A pop happens when mem_rvalid && outstanding != 0. The popped head decides the response:
  - kill = 0, tag = 0: if_data <= mem_rdata, if_valid <= 1.
  - kill = 0, tag = 1: ls_data <= mem_rdata, ls_valid <= 1.
  - kill = 1: the word is dropped. No valid pulse; the data registers are unchanged.
- flush sets kill = 1 on every entry present before the edge.
  - An entry pushed in the same cycle as flush is not killed.
  - A pop in the same cycle as flush is routed using the head's pre-flush kill bit.
- mem_rvalid while outstanding == 0: the word is dropped and err_orphan <= 1. Same-cycle bypass from issue to response is not supported, so an entry pushed in that same cycle is not consumed.
- issue_ready = (outstanding != DEPTH). It is purely registered state, with no path from mem_rvalid.
  - issue_ready stays 0 when full, even in a cycle that pops.
  - issue_valid while issue_ready = 0 is ignored; the upstream request select must not assert it.
- Push and pop in the same cycle: outstanding is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. outstanding is tracked as a separate counter.

## Timing
- Reset values: issue_ready = 1, outstanding = 0, if_valid = 0, ls_valid = 0, if_data = 0, ls_data = 0, err_orphan = 0.
- Reset clears all pointers and kill bits.
- Reset takes priority over every other input on the same edge. In-flight reads are forgotten, and later responses to them raise err_orphan.
- Latency: mem_rvalid at edge N produces the valid pulse and new data visible after edge N, for one cycle.
- outstanding and issue_ready update on the same edge as the push or pop.
- Back-to-back responses on consecutive cycles are supported, giving one pop per cycle.

## Structure
- Shared package (mem_pkg) holds:
  - TAG_IF = 1'b0 and TAG_LS = 1'b1.
  - The tag entry struct {tag, kill}, reused by the request-side select.
- Sub-module tag_fifo contains the parameterised DEPTH entry array and pointers. It has these ports:
  - push
  - push_tag
  - pop
  - flush
  - head_tag
  - head_kill
  - count
  - full
  - empty
- mem_resp_router contains the pop and route logic, the output registers, and the orphan detection.

## Test plan
- Reset then idle: all outputs at their reset values; issue_ready = 1 and outstanding = 0 for 10 cycles.
- Issue IF, LS, IF, then responses 0xA, 0xB, 0xC one cycle apart. Required:
  - if_valid pulses carrying 0xA, then 0xC.
  - An ls_valid pulse carrying 0xB between them.
  - outstanding stepping down 3 → 0.
- Issue 4 reads to reach full:
  - issue_ready = 0.
  - A 5th issue_valid is ignored.
  - A response pops the FIFO; issue_ready = 1 one cycle later.
- Issue 2 IF reads, assert flush together with a third LS issue, then return 0x1, 0x2, 0x3. Required:
  - 0x1 and 0x2 produce no pulse.
  - 0x3 produces ls_valid with ls_data = 0x3.
  - if_data still holds its previous value.
- mem_rvalid with 0xDEAD while empty: err_orphan pulses for one cycle; if_data and ls_data are unchanged.
- Simultaneous push and pop at outstanding = 2, across a pointer wrap: outstanding stays 2, and the routing order is preserved over 8 random tags.
